dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/riscv_mem_pkg.sv | 8 +
 rtl/dmem_array.sv | 23 ++
 rtl/dmem_responder.sv | 81 ++++++++
 tb/tb_dmem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: responder FSM states and the access-error rule shared by the data-memory blocks
package riscv_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return ((addr[1:0] & ALIGN_MASK) != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with one synchronous port, byte-enabled write and registered read
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end else if (en) begin
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with fixed wait states in front of dmem_array
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  dmem_state_t state, state_nx;
  logic up, we_q, err_q, accept, fire, err_cur, we_cur;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q, wdata_q, addr_cur, wdata_cur, rdata;
  logic [3:0] be_q, be_cur;
  assign accept = state == IDLE && up && req_valid;
  assign fire = state != RESP && state_nx == RESP;
  assign addr_cur = state == IDLE ? req_addr : addr_q;
  assign wdata_cur = state == IDLE ? req_wdata : wdata_q;
  assign be_cur = state == IDLE ? req_be : be_q;
  assign we_cur = state == IDLE ? req_we : we_q;
  assign err_cur = addr_err(addr_cur, DEPTH_WORDS);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      up <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      up <= 1'b1;
      cnt <= accept ? CNT_INIT : (state == WAIT && cnt != '0) ? cnt - CW'(1) : '0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
    end else if (accept) begin
      we_q <= req_we;
      err_q <= err_cur;
      addr_q <= req_addr;
      wdata_q <= req_wdata;
      be_q <= req_be;
    end
  end
  always_comb
    state_nx = state == IDLE ? (accept ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE)
             : state == WAIT ? (cnt == '0 ? RESP : WAIT)
             : (rsp_ready ? IDLE : RESP);
  always_comb begin
    req_ready = state == IDLE && up;
    rsp_valid = state == RESP;
    rsp_err = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !we_q && !err_q) ? rdata : '0;
  end
  dmem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
    .clk  (clk),
    .en   (fire && !err_cur),
    .we   (we_cur),
    .addr (addr_cur[AW+1:2]),
    .be   (be_cur),
    .wdata(wdata_cur),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a transaction-level model
module tb_dmem_responder;
  localparam int W = 2;
  localparam int D = 256;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_be = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic rst_z = 0, req_valid_z = 0, rsp_ready_z = 1;
  logic [31:0] req_addr_z = 0;
  logic req_ready_z, rsp_valid_z, rsp_err_z;
  logic [31:0] rsp_rdata_z;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH_WORDS(D), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  dmem_responder #(.DEPTH_WORDS(D), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst_z), .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(1'b0),
    .req_addr(req_addr_z), .req_wdata(32'h0), .req_be(4'h0), .rsp_valid(rsp_valid_z),
    .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  logic [31:0] mm [D];
  bit up, busy, m_we, e_err;
  int rem;
  logic [31:0] m_addr, m_wdata, e_rdata;
  logic [3:0] m_be;
  function automatic bit bad(input logic [31:0] a);
    return a[1:0] != 2'b00 || a[31:2] >= D;
  endfunction
  task automatic commit();
    int idx = int'(m_addr[31:2]);
    e_err = bad(m_addr);
    e_rdata = 0;
    if (!e_err && m_we) begin
      for (int i = 0; i < 4; i++) if (m_be[i]) mm[idx][8*i +: 8] = m_wdata[8*i +: 8];
    end else if (!e_err) begin
      e_rdata = mm[idx];
    end
  endtask
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      up = 0;
      busy = 0;
      rem = 0;
    end else if (!up) begin
      up = 1;
    end else if (!busy) begin
      if (req_valid) begin
        m_we = req_we;
        m_addr = req_addr;
        m_wdata = req_wdata;
        m_be = req_be;
        busy = 1;
        rem = W;
        if (W == 0) commit();
      end
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) commit();
    end else if (rsp_ready) begin
      busy = 0;
    end
  end
  always @(negedge clk) begin
    bit ev;
    ev = busy && rem == 0;
    chk("req_ready", req_ready, rst && up && !busy);
    chk("rsp_valid", rsp_valid, ev);
    if (ev || !rst) begin
      chk("rsp_rdata", rsp_rdata, ev ? e_rdata : 0);
      chk("rsp_err", rsp_err, ev ? e_err : 0);
    end
  end
  task automatic xact(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                      input int hold, output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    bit ok;
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_be = be; rsp_ready = 0;
    do begin
      @(negedge clk); ok = req_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 40);
    if (!ok) chk("accept_timeout", 0, 1);
    req_valid = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 40);
    if (!rsp_valid) chk("response_timeout", 0, 1);
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_err", rsp_err, er);
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    @(negedge clk);
    chk("req_ready_after_hs", req_ready, 1);
  endtask
  function automatic logic [31:0] rand_addr();
    int k = $urandom_range(0, 9);
    if (k == 0) return 32'($urandom_range(0, 1023));
    if (k == 1) return $urandom_range(0, 1) ? 32'h400 + 32'($urandom_range(0, 255) << 2) : $urandom;
    return 32'($urandom_range(0, 63) << 2);
  endfunction
  initial begin
    logic [31:0] rd;
    logic er;
    int lat, acc;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk); chk("ready_before_first_edge", req_ready, 0);
    @(negedge clk); chk("ready_after_first_edge", req_ready, 1);
    for (int i = 0; i < D; i++) xact(1, 32'(i * 4), 0, 4'hF, 0, rd, er, lat);
    xact(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    chk("st10_err", er, 0); chk("st10_lat", lat, 3);
    xact(0, 32'h10, 0, 4'h0, 0, rd, er, lat);
    chk("ld10_data", rd, 32'hDEADBEEF); chk("ld10_err", er, 0); chk("ld10_lat", lat, 3);
    xact(1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat);
    xact(1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
    xact(0, 32'h20, 0, 4'h0, 0, rd, er, lat);
    chk("ld20_merge", rd, 32'h11BB33DD);
    xact(0, 32'h22, 0, 4'h0, 0, rd, er, lat);
    chk("ld22_err", er, 1); chk("ld22_data", rd, 0);
    xact(0, 32'h400, 0, 4'h0, 0, rd, er, lat);
    chk("ld400_err", er, 1); chk("ld400_data", rd, 0);
    xact(1, 32'h22, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
    chk("st22_err", er, 1);
    xact(0, 32'h20, 0, 4'h0, 5, rd, er, lat);
    chk("ld20_unchanged", rd, 32'h11BB33DD);
    xact(1, 32'h10, 32'h12345678, 4'h0, 0, rd, er, lat);
    chk("be0_err", er, 0);
    xact(0, 32'h10, 0, 4'h0, 0, rd, er, lat);
    chk("be0_nochange", rd, 32'hDEADBEEF);
    @(posedge clk); #1;
    req_valid = 1; req_we = 1; req_addr = 32'h30; req_wdata = 32'h55; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", req_ready, 0); chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0); chk("rst_err", rsp_err, 0);
    @(posedge clk); #1 rst = 1;
    xact(0, 32'h30, 0, 4'h0, 0, rd, er, lat);
    chk("ld30_abandoned", rd, 0);
    xact(0, 32'h10, 0, 4'h0, 0, rd, er, lat);
    chk("ld10_persist", rd, 32'hDEADBEEF);
    @(posedge clk); #1 rst_z = 1;
    @(posedge clk); #1 req_valid_z = 1;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      bit a;
      @(negedge clk);
      chk("w0_ready", req_ready_z, k % 2 == 0);
      chk("w0_valid", rsp_valid_z, k % 2 == 1);
      if (rsp_valid_z) chk("w0_err", rsp_err_z, 0);
      a = req_ready_z && req_valid_z;
      @(posedge clk); #1;
      if (a) begin
        acc++;
        req_addr_z = req_addr_z + 4;
        if (acc == 4) req_valid_z = 0;
      end
    end
    chk("w0_accepts", acc, 4);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (!rst) rst = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 99) == 0) rst = 0;
      req_valid = $urandom_range(0, 2) != 0;
      req_we = 1'($urandom_range(0, 1));
      req_addr = rand_addr();
      req_wdata = $urandom;
      req_be = 4'($urandom_range(0, 15));
      rsp_ready = $urandom_range(0, 2) != 0;
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
